fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID latch.
//  Owns the PC, issues word reads to the icache via the imemREN/ihit handshake, and delivers
//  {instr, pc_next} plus enable/nop controls to IF/ID. Handles ID stalls with a one-entry hold
//  buffer, branch/jump redirects (including during an outstanding miss) and halt detection.
// PARAMETERS
//  PC_RESET  32'h0000_0000  PC value loaded on reset
//  HALT_OP   6'b111111      opcode (instr[31:26]) recognised as HALT
// PORTS
//  CLK          in   1   clock, rising edge
//  nRST         in   1   reset, asynchronous, active-low
//  ihit         in   1   icache: imemload valid for imemaddr this cycle
//  imemload     in   32  icache: instruction word
//  imemREN      out  1   icache read request
//  imemaddr     out  32  icache word address (bits[1:0]=0)
//  stall        in   1   hazard unit: hold IF/ID contents
//  redirect     in   1   branch/jump taken; flush and refetch from redirect_pc
//  redirect_pc  in   32  redirect target; bits[1:0] forced to 0 on capture
//  instr        out  32  instruction to IF/ID
//  pc_next      out  32  PC+4 of delivered instruction, to IF/ID
//  ifid_en      out  1   IF/ID load enable (delivery this cycle)
//  ifid_nop     out  1   IF/ID clear (bubble/flush)
//  halted       out  1   fetch stopped on HALT
// BEHAVIOUR
//  Regs: pc, state, tgt (pending target), buf_instr, buf_pcn. Reset: pc=PC_RESET, state=FETCH,
//   tgt/buf_*=0. While nRST=0: imemREN=0, ifid_en=0, ifid_nop=0, halted=0, instr=0, pc_next=0.
//  Reset mid-miss simply abandons the request; first cycle after release fetches PC_RESET.
//  pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). All outputs below are combinational from regs
//   and inputs; IF/ID samples them at the next edge (zero added latency; a hit delivers same cycle).
//  Default each cycle: ifid_en=0; ifid_nop = redirect | ~stall (bubble when nothing delivered).
//  Redirect has priority over stall and over delivery in every state; ifid_nop=1, ifid_en=0.
//  FETCH: imemREN=1, imemaddr=pc.
//   redirect & ihit  -> pc<=redirect_pc; stay FETCH (hit data discarded).
//   redirect & ~ihit -> tgt<=redirect_pc; -> SQUASH (address held until ihit; cache never sees
//                       an address change mid-miss).
//   ihit & ~stall    -> ifid_en=1, ifid_nop=0, instr=imemload, pc_next=pc+4; pc<=pc+4;
//                       -> HALTED if imemload[31:26]==HALT_OP else FETCH.
//   ihit & stall     -> buf_instr<=imemload, buf_pcn<=pc+4, pc<=pc+4; -> HOLD.
//   ~ihit            -> stay; bubble per default.
//  HOLD: imemREN=0. instr=buf_instr, pc_next=buf_pcn.
//   redirect -> pc<=redirect_pc, buffer dropped; -> FETCH.
//   ~stall   -> ifid_en=1, ifid_nop=0; -> HALTED if buf_instr is HALT else FETCH.
//   stall    -> stay (ifid_en=0, ifid_nop=0).
//  SQUASH: imemREN=1, imemaddr=pc (old). redirect -> tgt<=redirect_pc (newest wins).
//   ihit -> data discarded, pc<=tgt (or redirect_pc if redirect same cycle); -> FETCH.
//  HALTED: imemREN=0, halted=1, bubbles per default. Redirect -> pc<=redirect_pc; -> FETCH
//   (HALT on a squashed path must not stop the machine). Otherwise stays until reset.
//  instr/pc_next = 0 in states/cycles with no delivery and not HOLD.
//  Invariant: ifid_en & ifid_nop never both 1; at most one delivery per PC value.
// TESTING
//  1 Reset, ihit=1 every cycle, stall=0: imemaddr 0,4,8,... ifid_en=1 each cycle,
//    pc_next=addr+4; assert nRST mid-run -> outputs 0 at once, restart at PC_RESET.
//  2 Miss 3 cycles at 0x10, stall=0: ifid_nop=1 x3, then ifid_en=1 instr=imemload pc_next=0x14.
//  3 Hit at 0x20 with stall=1 for 2 cycles: imemREN=0 in HOLD, IF/ID held (en=0,nop=0),
//    then delivered with pc_next=0x24; next request 0x24, no duplicate, no skip.
//  4 Redirect to 0x103 during miss at 0x40: imemaddr stays 0x40 until ihit, data dropped,
//    next imemaddr=0x100; second redirect to 0x200 in SQUASH -> next fetch 0x200.
//  5 Fetch word 0xFC000000 at 0x80: delivered, halted=1, imemREN=0; redirect to 0x300 ->
//    halted=0, fetch 0x300; without redirect stays halted >=10 cycles.
//  6 pc=32'hFFFF_FFFC hit -> pc_next=0, next imemaddr=0; redirect & stall same cycle -> nop=1.

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - icache, hazard-unit and IF/ID signals of the fetch stage
// master is the fetch unit; slave is the surrounding pipeline / icache.
interface fetch_unit_if;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] pc_next;
    logic        ifid_en;
    logic        ifid_nop;
    logic        halted;

    modport master (
        input  ihit, imemload, stall, redirect, redirect_pc,
        output imemREN, imemaddr, instr, pc_next, ifid_en, ifid_nop, halted
    );

    modport slave (
        output ihit, imemload, stall, redirect, redirect_pc,
        input  imemREN, imemaddr, instr, pc_next, ifid_en, ifid_nop, halted
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS instruction fetch stage with stall hold buffer and redirect squash
// Outputs are combinational from state and inputs so a hit reaches IF/ID in the same cycle.
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = 6'b111111
) (
    input  logic        CLK,
    input  logic        nRST,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pcn_q, buf_pcn_d;

    logic [31:0] pc_plus4;
    logic [31:0] rpc;

    assign pc_plus4 = pc_q + 32'd4;
    assign rpc      = bus.redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= FETCH;
            pc_q        <= PC_RESET;
            tgt_q       <= 32'd0;
            buf_instr_q <= 32'd0;
            buf_pcn_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            buf_instr_q <= buf_instr_d;
            buf_pcn_q   <= buf_pcn_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        buf_instr_d  = buf_instr_q;
        buf_pcn_d    = buf_pcn_q;
        bus.imemREN  = 1'b0;
        bus.imemaddr = pc_q;
        bus.instr    = 32'd0;
        bus.pc_next  = 32'd0;
        bus.ifid_en  = 1'b0;
        bus.ifid_nop = bus.redirect | ~bus.stall;
        bus.halted   = 1'b0;

        case (state_q)
            FETCH: begin
                bus.imemREN = 1'b1;
                if (bus.redirect) begin
                    // A miss must finish at the old address before the target is fetched.
                    if (bus.ihit) begin
                        pc_d = rpc;
                    end else begin
                        tgt_d   = rpc;
                        state_d = SQUASH;
                    end
                end else if (bus.ihit) begin
                    pc_d = pc_plus4;
                    if (!bus.stall) begin
                        bus.ifid_en  = 1'b1;
                        bus.ifid_nop = 1'b0;
                        bus.instr    = bus.imemload;
                        bus.pc_next  = pc_plus4;
                        state_d      = (bus.imemload[31:26] == HALT_OP) ? HALTED : FETCH;
                    end else begin
                        buf_instr_d = bus.imemload;
                        buf_pcn_d   = pc_plus4;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                bus.instr   = buf_instr_q;
                bus.pc_next = buf_pcn_q;
                if (bus.redirect) begin
                    pc_d    = rpc;
                    state_d = FETCH;
                end else if (!bus.stall) begin
                    bus.ifid_en  = 1'b1;
                    bus.ifid_nop = 1'b0;
                    state_d      = (buf_instr_q[31:26] == HALT_OP) ? HALTED : FETCH;
                end
            end
            SQUASH: begin
                bus.imemREN = 1'b1;
                if (bus.ihit) begin
                    pc_d    = bus.redirect ? rpc : tgt_q;
                    state_d = FETCH;
                end else if (bus.redirect) begin
                    tgt_d = rpc;
                end
            end
            HALTED: begin
                bus.halted = 1'b1;
                if (bus.redirect) begin
                    pc_d    = rpc;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // Reset is asynchronous, so the outputs are forced quiet without waiting for an edge.
        if (!nRST) begin
            bus.imemREN  = 1'b0;
            bus.imemaddr = 32'd0;
            bus.instr    = 32'd0;
            bus.pc_next  = 32'd0;
            bus.ifid_en  = 1'b0;
            bus.ifid_nop = 1'b0;
            bus.halted   = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - vector table, corner sequences and random model check of fetch_unit
module tb_fetch_unit;

    logic CLK;
    logic nRST;
    fetch_unit_if bus ();

    fetch_unit dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        ih;
        logic [31:0] ld;
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        ren;
        logic [31:0] addr;
        logic        en;
        logic        nop;
        logic [31:0] ins;
        logic [31:0] pcn;
        logic        hlt;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] m_pc;
    bit          m_halted;
    logic [63:0] holdq[$];
    logic [31:0] pendq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic ren, input logic [31:0] addr,
                           input logic en, input logic nop, input logic [31:0] ins,
                           input logic [31:0] pcn, input logic hlt);
        chk({nm, ".imemREN"}, {31'd0, bus.imemREN}, {31'd0, ren});
        if (ren) chk({nm, ".imemaddr"}, bus.imemaddr, addr);
        chk({nm, ".ifid_en"}, {31'd0, bus.ifid_en}, {31'd0, en});
        chk({nm, ".ifid_nop"}, {31'd0, bus.ifid_nop}, {31'd0, nop});
        chk({nm, ".instr"}, bus.instr, ins);
        chk({nm, ".pc_next"}, bus.pc_next, pcn);
        chk({nm, ".halted"}, {31'd0, bus.halted}, {31'd0, hlt});
    endtask

    task automatic drive(input logic ih, input logic [31:0] ld, input logic st,
                         input logic rd, input logic [31:0] rpc);
        bus.ihit        = ih;
        bus.imemload    = ld;
        bus.stall       = st;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
    endtask

    task automatic addv(input logic ih, input logic [31:0] ld, input logic st, input logic rd,
                        input logic [31:0] rpc, input logic ren, input logic [31:0] addr,
                        input logic en, input logic nop, input logic [31:0] ins,
                        input logic [31:0] pcn, input logic hlt);
        vec_t v;
        v.ih = ih; v.ld = ld; v.st = st; v.rd = rd; v.rpc = rpc;
        v.ren = ren; v.addr = addr; v.en = en; v.nop = nop;
        v.ins = ins; v.pcn = pcn; v.hlt = hlt;
        vq.push_back(v);
    endtask

    // Leaves time at one step past a rising edge with reset just released.
    task automatic reset_dut();
        nRST = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    function automatic logic [31:0] memw(input logic [31:0] a);
        logic [31:0] w;
        w = a * 32'h9E37_79B9 + 32'h1234_5678;
        if (((a >> 2) % 13) == 5) w[31:26] = 6'b111111;
        else if (w[31:26] == 6'b111111) w[31:26] = 6'b000000;
        return w;
    endfunction

    // Reference: a pending-target queue and a one-entry delivery queue stand in for the modes.
    task automatic model_step(input logic ih, input logic [31:0] ld, input logic st,
                              input logic rd, input logic [31:0] rpc_raw,
                              output logic ren, output logic [31:0] addr, output logic en,
                              output logic nop, output logic [31:0] ins,
                              output logic [31:0] pcn, output logic hlt);
        logic [31:0] rpc;
        rpc  = rpc_raw & 32'hFFFF_FFFC;
        en   = 1'b0;
        nop  = rd | ~st;
        ren  = 1'b0;
        addr = m_pc;
        ins  = 32'd0;
        pcn  = 32'd0;
        hlt  = 1'b0;
        if (m_halted) begin
            hlt = 1'b1;
            if (rd) begin
                m_halted = 1'b0;
                m_pc     = rpc;
            end
        end else if (holdq.size() != 0) begin
            ins = holdq[0][63:32];
            pcn = holdq[0][31:0];
            if (rd) begin
                holdq.delete();
                m_pc = rpc;
            end else if (!st) begin
                en       = 1'b1;
                nop      = 1'b0;
                m_halted = (ins[31:26] == 6'b111111);
                holdq.delete();
            end else begin
                nop = 1'b0;
            end
        end else if (pendq.size() != 0) begin
            ren = 1'b1;
            if (ih) begin
                m_pc = rd ? rpc : pendq[0];
                pendq.delete();
            end else if (rd) begin
                pendq[0] = rpc;
            end
        end else begin
            ren = 1'b1;
            if (rd) begin
                if (ih) m_pc = rpc;
                else    pendq.push_back(rpc);
            end else if (ih) begin
                if (!st) begin
                    en       = 1'b1;
                    nop      = 1'b0;
                    ins      = ld;
                    pcn      = m_pc + 32'd4;
                    m_halted = (ld[31:26] == 6'b111111);
                end else begin
                    holdq.push_back({ld, m_pc + 32'd4});
                end
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        logic        e_ren, e_en, e_nop, e_hlt;
        logic [31:0] e_addr, e_ins, e_pcn;
        logic        r_ih, r_st, r_rd;
        logic [31:0] r_ld, r_rpc;

        // Vector table: each row is one cycle, starting from a fresh reset at pc 0.
        addv(1, 32'hDEAD_0000, 0, 1, 32'h10,  1, 32'h0,  0, 1, 32'h0, 32'h0, 0);
        addv(0, 32'h0, 0, 0, 32'h0,           1, 32'h10, 0, 1, 32'h0, 32'h0, 0);
        addv(0, 32'h0, 0, 0, 32'h0,           1, 32'h10, 0, 1, 32'h0, 32'h0, 0);
        addv(0, 32'h0, 0, 0, 32'h0,           1, 32'h10, 0, 1, 32'h0, 32'h0, 0);
        addv(1, 32'h2222_0010, 0, 0, 32'h0,   1, 32'h10, 1, 0, 32'h2222_0010, 32'h14, 0);
        addv(1, 32'h1111_1111, 0, 1, 32'h20,  1, 32'h14, 0, 1, 32'h0, 32'h0, 0);
        addv(1, 32'h3333_0020, 1, 0, 32'h0,   1, 32'h20, 0, 0, 32'h0, 32'h0, 0);
        addv(0, 32'h0, 1, 0, 32'h0,           0, 32'h0,  0, 0, 32'h3333_0020, 32'h24, 0);
        addv(0, 32'h0, 0, 0, 32'h0,           0, 32'h0,  1, 0, 32'h3333_0020, 32'h24, 0);
        addv(1, 32'h4444_0024, 0, 0, 32'h0,   1, 32'h24, 1, 0, 32'h4444_0024, 32'h28, 0);
        addv(1, 32'h1111_1111, 0, 1, 32'h40,  1, 32'h28, 0, 1, 32'h0, 32'h0, 0);
        addv(0, 32'h0, 0, 1, 32'h103,         1, 32'h40, 0, 1, 32'h0, 32'h0, 0);
        addv(0, 32'h0, 0, 0, 32'h0,           1, 32'h40, 0, 1, 32'h0, 32'h0, 0);
        addv(1, 32'h5555_0040, 0, 0, 32'h0,   1, 32'h40, 0, 1, 32'h0, 32'h0, 0);
        addv(0, 32'h0, 0, 1, 32'h1F0,         1, 32'h100, 0, 1, 32'h0, 32'h0, 0);
        addv(0, 32'h0, 0, 1, 32'h200,         1, 32'h100, 0, 1, 32'h0, 32'h0, 0);
        addv(1, 32'h5555_0100, 0, 0, 32'h0,   1, 32'h100, 0, 1, 32'h0, 32'h0, 0);
        addv(1, 32'h6666_0200, 0, 0, 32'h0,   1, 32'h200, 1, 0, 32'h6666_0200, 32'h204, 0);
        addv(0, 32'h0, 0, 1, 32'h500,         1, 32'h204, 0, 1, 32'h0, 32'h0, 0);
        addv(1, 32'h5555_0204, 0, 1, 32'h80,  1, 32'h204, 0, 1, 32'h0, 32'h0, 0);
        addv(1, 32'hFC00_0000, 0, 0, 32'h0,   1, 32'h80, 1, 0, 32'hFC00_0000, 32'h84, 0);
        addv(1, 32'h1111_1111, 0, 0, 32'h0,   0, 32'h0,  0, 1, 32'h0, 32'h0, 1);
        addv(0, 32'h0, 0, 1, 32'h300,         0, 32'h0,  0, 1, 32'h0, 32'h0, 1);
        addv(0, 32'h0, 0, 0, 32'h0,           1, 32'h300, 0, 1, 32'h0, 32'h0, 0);
        addv(1, 32'h1111_1111, 0, 1, 32'hFFFF_FFFE, 1, 32'h300, 0, 1, 32'h0, 32'h0, 0);
        addv(1, 32'h7777_7777, 0, 0, 32'h0,   1, 32'hFFFF_FFFC, 1, 0, 32'h7777_7777, 32'h0, 0);
        addv(1, 32'h8888_0000, 1, 1, 32'h40,  1, 32'h0,  0, 1, 32'h0, 32'h0, 0);
        addv(1, 32'h9999_0040, 1, 0, 32'h0,   1, 32'h40, 0, 0, 32'h0, 32'h0, 0);
        addv(0, 32'h0, 1, 1, 32'h10,          0, 32'h0,  0, 1, 32'h9999_0040, 32'h44, 0);
        addv(1, 32'hAAAA_0010, 0, 0, 32'h0,   1, 32'h10, 1, 0, 32'hAAAA_0010, 32'h14, 0);
        addv(1, 32'hFC00_0001, 1, 0, 32'h0,   1, 32'h14, 0, 0, 32'h0, 32'h0, 0);
        addv(0, 32'h0, 0, 0, 32'h0,           0, 32'h0,  1, 0, 32'hFC00_0001, 32'h18, 0);
        addv(0, 32'h0, 0, 0, 32'h0,           0, 32'h0,  0, 1, 32'h0, 32'h0, 1);

        // Outputs quiet while reset is held.
        nRST = 1'b0;
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
        @(negedge CLK);
        chk_all("reset", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Continuous hits stream sequential addresses, then an asynchronous mid-run reset.
        @(posedge CLK);
        #1 nRST = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h0000_1000 + i, 1'b0, 1'b0, 32'h0);
            @(negedge CLK);
            chk_all($sformatf("stream%0d", i), 1'b1, 32'(i * 4), 1'b1, 1'b0,
                    32'h0000_1000 + i, 32'(i * 4 + 4), 1'b0);
            @(posedge CLK);
            #1;
        end
        #1 nRST = 1'b0;
        #1 chk_all("midreset", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge CLK);
        #1 nRST = 1'b1;
        drive(1'b1, 32'h0000_2000, 1'b0, 1'b0, 32'h0);
        @(negedge CLK);
        chk_all("restart", 1'b1, 32'h0, 1'b1, 1'b0, 32'h0000_2000, 32'h4, 1'b0);

        reset_dut();
        foreach (vq[i]) begin
            drive(vq[i].ih, vq[i].ld, vq[i].st, vq[i].rd, vq[i].rpc);
            @(negedge CLK);
            chk_all($sformatf("vec%0d", i), vq[i].ren, vq[i].addr, vq[i].en, vq[i].nop,
                    vq[i].ins, vq[i].pcn, vq[i].hlt);
            @(posedge CLK);
            #1;
        end

        // Halted with no redirect ignores hits and stalls indefinitely.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 32'h0000_3000, i[0], 1'b0, 32'h0);
            @(negedge CLK);
            chk_all($sformatf("halthold%0d", i), 1'b0, 32'h0, 1'b0, ~i[0], 32'h0, 32'h0, 1'b1);
            @(posedge CLK);
            #1;
        end

        reset_dut();
        m_pc     = 32'h0;
        m_halted = 1'b0;
        holdq.delete();
        pendq.delete();
        for (int c = 0; c < 2000; c++) begin
            r_ih  = ($urandom_range(0, 3) != 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_rd  = ($urandom_range(0, 9) == 0);
            r_rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
            r_ld  = memw(m_pc);
            drive(r_ih, r_ld, r_st, r_rd, r_rpc);
            model_step(r_ih, r_ld, r_st, r_rd, r_rpc,
                       e_ren, e_addr, e_en, e_nop, e_ins, e_pcn, e_hlt);
            @(negedge CLK);
            chk_all($sformatf("rand%0d", c), e_ren, e_addr, e_en, e_nop, e_ins, e_pcn, e_hlt);
            @(posedge CLK);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
